// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the fetch/execute responder.
package cpu_bus_pkg;

  localparam logic [7:0] HALT_OP = 8'hFF;

  typedef enum logic [2:0] {
    PH_OPC,
    PH_OPND0,
    PH_OPND1,
    PH_OPND2,
    PH_OPND3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  // Replace the operand byte selected by an operand phase; other bytes kept.
  function automatic logic [31:0] merge_operand(input logic [31:0] word,
                                                input phase_e      ph,
                                                input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (ph)
      PH_OPND0: r[7:0]   = b;
      PH_OPND1: r[15:8]  = b;
      PH_OPND2: r[23:16] = b;
      PH_OPND3: r[31:24] = b;
      default:  r        = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts cycles spent waiting for a memory acknowledge; flags the last allowed one.
module bus_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int unsigned   CW   = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] r_cnt;

  // o_expired is high during the MAX_WAIT-th counted cycle.
  assign o_expired = i_count && (r_cnt == LAST);

  // Cycle counter: cleared as a request is accepted, advances while waiting.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_count && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_exec_responder.sv
// Responder side of the CPU timing handshake: one memory read per bus phase,
// a one-cycle done per completed phase, and opcode decode for stop/cnt_set.
module fetch_exec_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          T1_Mif,
  input  logic          T2_Mif,
  input  logic          T1,
  input  logic          T2,
  input  logic          T3,
  input  logic          T4,
  output logic          done,
  output logic          stop,
  output logic [1:0]    cnt_set,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_load_val,
  output logic [7:0]    opcode,
  output logic [31:0]   operand,
  output logic [AW-1:0] pc,
  output logic          bus_err,
  output logic          ovl_err
);

  state_e        r_state;
  state_e        w_state_nxt;
  phase_e        r_phase;
  phase_e        w_phase_sel;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_opcode;
  logic [31:0]   r_operand;
  logic          r_stop;
  logic [1:0]    r_cnt_set;
  logic          r_bus_err;
  logic          r_ovl_err;

  logic [4:0]    w_starts;
  logic          w_any_start;
  logic          w_multi;
  logic          w_start;
  logic          w_finish;
  logic          w_timeout;
  logic          w_expired;
  logic          w_ovl_set;
  logic [7:0]    w_data;
  logic          w_unused;

  // T2_Mif marks a phase with no bus traffic, so it never starts or overlaps a read.
  assign w_unused    = T2_Mif;

  assign w_starts    = {T1_Mif, T1, T2, T3, T4};
  assign w_any_start = |w_starts;
  assign w_multi     = (w_starts & (w_starts - 5'd1)) != 5'd0;
  assign w_ovl_set   = (r_state == ST_IDLE) ? w_multi : w_any_start;
  assign w_data      = w_timeout ? 8'h00 : mem_rdata;

  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign opcode   = r_opcode;
  assign operand  = r_operand;
  assign stop     = r_stop;
  assign cnt_set  = r_cnt_set;
  assign bus_err  = r_bus_err;
  assign ovl_err  = r_ovl_err;

  bus_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start),
    .i_count  (r_state == ST_REQ),
    .o_expired(w_expired)
  );

  // Fixed-priority phase selection: T1_Mif > T1 > T2 > T3 > T4.
  always_comb begin
    w_phase_sel = PH_OPC;
    if (T1_Mif)  w_phase_sel = PH_OPC;
    else if (T1) w_phase_sel = PH_OPND0;
    else if (T2) w_phase_sel = PH_OPND1;
    else if (T3) w_phase_sel = PH_OPND2;
    else if (T4) w_phase_sel = PH_OPND3;
  end

  // FSM next state and bus/handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    mem_req     = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_start) begin
          w_start     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_expired) begin
          w_finish    = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: PC, captured opcode/operand, decode and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase   <= PH_OPC;
      r_pc      <= AW'(RESET_PC);
      r_opcode  <= '0;
      r_operand <= '0;
      r_stop    <= 1'b0;
      r_cnt_set <= '0;
      r_bus_err <= 1'b0;
      r_ovl_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_phase <= w_phase_sel;
      end
      // A load in IDLE lands before REQ, so a same-cycle read uses the new PC.
      if (r_state == ST_IDLE && pc_load) begin
        r_pc <= pc_load_val;
      end
      if (w_finish) begin
        r_pc <= r_pc + AW'(1);
        if (w_timeout) begin
          r_bus_err <= 1'b1;
        end
        if (r_phase == PH_OPC) begin
          r_opcode  <= w_data;
          r_operand <= '0;
          r_cnt_set <= w_data[1:0];
          r_stop    <= (w_data == HALT_OP);
        end else begin
          r_operand <= merge_operand(r_operand, r_phase, w_data);
        end
      end
      if (w_ovl_set) begin
        r_ovl_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_exec_responder.sv
// Self-checking bench for fetch_exec_responder: directed vector table,
// randomized phases against a behavioural model, and multi-cycle corner cases.
module tb_fetch_exec_responder;
  import cpu_bus_pkg::*;

  localparam int unsigned AW = 8;
  localparam int          MW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          T1_Mif, T2_Mif, T1, T2, T3, T4;
  logic          done, stop, mem_req, mem_ack, pc_load, bus_err, ovl_err;
  logic [1:0]    cnt_set;
  logic [AW-1:0] mem_addr, pc_load_val, pc;
  logic [7:0]    mem_rdata, opcode;
  logic [31:0]   operand;

  fetch_exec_responder #(
    .AW      (AW),
    .MAX_WAIT(MW),
    .RESET_PC(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .T1_Mif     (T1_Mif),
    .T2_Mif     (T2_Mif),
    .T1         (T1),
    .T2         (T2),
    .T3         (T3),
    .T4         (T4),
    .done       (done),
    .stop       (stop),
    .cnt_set    (cnt_set),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .pc_load    (pc_load),
    .pc_load_val(pc_load_val),
    .opcode     (opcode),
    .operand    (operand),
    .pc         (pc),
    .bus_err    (bus_err),
    .ovl_err    (ovl_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          ndone;
    int          nreq;
    logic [7:0]  addr;
    logic        unstable;
    logic [7:0]  opc;
    logic [31:0] opnd;
    logic [7:0]  pc;
    logic        stop;
    logic [1:0]  cnt;
    logic        berr;
    logic        ovl;
  } obs_t;

  typedef struct {
    logic [5:0] p;
    logic [7:0] data;
    int         waits;
    obs_t       exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  m_pc, m_opc;
  logic [31:0] m_opnd;
  logic        m_stop, m_berr, m_ovl;
  logic [1:0]  m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pulses(input logic [5:0] p);
    {T1_Mif, T2_Mif, T1, T2, T3, T4} = p;
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_opc = 8'h00; m_opnd = 32'h0;
    m_stop = 1'b0; m_cnt = 2'd0; m_berr = 1'b0; m_ovl = 1'b0;
  endtask

  // p bits: [5]=T1_Mif [4]=T2_Mif [3]=T1 [2]=T2 [1]=T3 [0]=T4.
  // waits<0 means no acknowledge ever; waits>=MW means the ack comes too late.
  task automatic model_phase(input logic [5:0] p, input logic [7:0] data, input int waits,
                             input logic ld, input logic [7:0] ldv, input logic [5:0] inj,
                             output obs_t e);
    logic [4:0] st;
    logic [4:0] st_inj;
    logic [7:0] d;
    bit         acked;
    int         k;
    e.lat = -1; e.ndone = 0; e.nreq = 0; e.addr = 8'h00; e.unstable = 1'b0;
    st     = {p[5], p[3:0]};
    st_inj = {inj[5], inj[3:0]};
    if (ld) m_pc = ldv;
    if (st != 5'd0) begin
      if ($countones(st) > 1) m_ovl = 1'b1;
      if (st_inj != 5'd0) m_ovl = 1'b1;
      acked = (waits >= 0) && (waits < MW);
      d = acked ? data : 8'h00;
      if (!acked) m_berr = 1'b1;
      e.lat   = acked ? waits + 2 : MW + 1;
      e.ndone = 1;
      e.nreq  = acked ? waits + 1 : MW;
      e.addr  = m_pc;
      m_pc    = m_pc + 8'd1;
      if (p[5]) begin
        m_opc  = d;
        m_opnd = 32'h0;
        m_cnt  = d[1:0];
        m_stop = (d == 8'hFF);
      end else begin
        k = p[3] ? 0 : p[2] ? 1 : p[1] ? 2 : 3;
        m_opnd[8*k +: 8] = d;
      end
    end
    e.opc = m_opc; e.opnd = m_opnd; e.pc = m_pc; e.stop = m_stop;
    e.cnt = m_cnt; e.berr = m_berr; e.ovl = m_ovl;
  endtask

  task automatic snapshot(inout obs_t o);
    o.opc = opcode; o.opnd = operand; o.pc = pc; o.stop = stop;
    o.cnt = cnt_set; o.berr = bus_err; o.ovl = ovl_err;
  endtask

  // Issue pulses p in cycle 0, act as memory, observe a fixed 24-cycle window.
  // Architectural state is sampled in the first done cycle (or at window end).
  task automatic run_phase(input logic [5:0] p, input logic [7:0] data, input int waits,
                           input logic ld, input logic [7:0] ldv,
                           input logic [5:0] inj, input int inj_c, output obs_t o);
    o.lat = -1; o.ndone = 0; o.nreq = 0; o.addr = 8'h00; o.unstable = 1'b0;
    snapshot(o);
    @(posedge clk); #1;
    set_pulses(p);
    pc_load = ld;
    pc_load_val = ldv;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      set_pulses((c == inj_c) ? inj : 6'b0);
      pc_load   = 1'b0;
      mem_ack   = (waits >= 0) && (c == waits + 1);
      mem_rdata = mem_ack ? data : 8'($urandom);
      @(negedge clk);
      if (mem_req) begin
        if (o.nreq == 0) o.addr = mem_addr;
        else if (mem_addr != o.addr) o.unstable = 1'b1;
        o.nreq++;
      end
      if (done) begin
        o.ndone++;
        if (o.lat < 0) begin
          o.lat = c;
          snapshot(o);
        end
      end
    end
    mem_ack = 1'b0;
    if (o.ndone == 0) snapshot(o);
  endtask

  task automatic cmp_obs(input string t, input obs_t o, input obs_t e);
    chk({t, ".done_cycle"}, o.lat, e.lat);
    chk({t, ".done_count"}, o.ndone, e.ndone);
    chk({t, ".req_cycles"}, o.nreq, e.nreq);
    if (e.nreq > 0) begin
      chk({t, ".mem_addr"}, o.addr, e.addr);
      chk({t, ".addr_unstable"}, o.unstable, 1'b0);
    end
    chk({t, ".opcode"}, o.opc, e.opc);
    chk({t, ".operand"}, o.opnd, e.opnd);
    chk({t, ".pc"}, o.pc, e.pc);
    chk({t, ".stop"}, o.stop, e.stop);
    chk({t, ".cnt_set"}, o.cnt, e.cnt);
    chk({t, ".bus_err"}, o.berr, e.berr);
    chk({t, ".ovl_err"}, o.ovl, e.ovl);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_pulses(6'b0);
    mem_ack = 1'b0; mem_rdata = 8'h00; pc_load = 1'b0; pc_load_val = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  function automatic vec_t mkv(input logic [5:0] p, input logic [7:0] data, input int waits,
                               input int lat, input int nreq, input logic [7:0] addr,
                               input logic [7:0] opc, input logic [31:0] opnd,
                               input logic [7:0] pcv, input logic st, input logic [1:0] cnt,
                               input logic berr, input logic ovl);
    vec_t v;
    v.p = p; v.data = data; v.waits = waits;
    v.exp.lat = lat; v.exp.ndone = (lat >= 0) ? 1 : 0; v.exp.nreq = nreq;
    v.exp.addr = addr; v.exp.unstable = 1'b0; v.exp.opc = opc; v.exp.opnd = opnd;
    v.exp.pc = pcv; v.exp.stop = st; v.exp.cnt = cnt; v.exp.berr = berr; v.exp.ovl = ovl;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[10];
    obs_t       o, e;
    logic [5:0] p;
    logic [7:0] data, ldv;
    int         waits, nd, nr;
    logic       ld;

    do_reset();
    chk("reset.mem_req", mem_req, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.stop", stop, 1'b0);
    chk("reset.cnt_set", cnt_set, 2'd0);
    chk("reset.opcode", opcode, 8'h00);
    chk("reset.operand", operand, 32'h0);
    chk("reset.pc", pc, 8'h00);
    chk("reset.bus_err", bus_err, 1'b0);
    chk("reset.ovl_err", ovl_err, 1'b0);

    //              p          data   w   lat nreq addr  opc    operand        pc    st cnt  be ov
    tbl[0] = mkv(6'b100000, 8'h02,  0,  2,  1, 8'h00, 8'h02, 32'h00000000, 8'h01, 0, 2'd2, 0, 0);
    tbl[1] = mkv(6'b001000, 8'h11,  3,  5,  4, 8'h01, 8'h02, 32'h00000011, 8'h02, 0, 2'd2, 0, 0);
    tbl[2] = mkv(6'b000100, 8'h22,  3,  5,  4, 8'h02, 8'h02, 32'h00002211, 8'h03, 0, 2'd2, 0, 0);
    tbl[3] = mkv(6'b000010, 8'h33,  3,  5,  4, 8'h03, 8'h02, 32'h00332211, 8'h04, 0, 2'd2, 0, 0);
    tbl[4] = mkv(6'b100000, 8'hFF,  1,  3,  2, 8'h04, 8'hFF, 32'h00000000, 8'h05, 1, 2'd3, 0, 0);
    tbl[5] = mkv(6'b010000, 8'h5C,  0, -1,  0, 8'h00, 8'hFF, 32'h00000000, 8'h05, 1, 2'd3, 0, 0);
    tbl[6] = mkv(6'b100000, 8'hAA, -1, 16, 15, 8'h05, 8'h00, 32'h00000000, 8'h06, 0, 2'd0, 1, 0);
    tbl[7] = mkv(6'b101000, 8'h41,  0,  2,  1, 8'h06, 8'h41, 32'h00000000, 8'h07, 0, 2'd1, 1, 1);
    tbl[8] = mkv(6'b000001, 8'h9D, 14, 16, 15, 8'h07, 8'h41, 32'h9D000000, 8'h08, 0, 2'd1, 1, 1);
    tbl[9] = mkv(6'b000001, 8'h77, 15, 16, 15, 8'h08, 8'h41, 32'h00000000, 8'h09, 0, 2'd1, 1, 1);

    for (int i = 0; i < 10; i++) begin
      run_phase(tbl[i].p, tbl[i].data, tbl[i].waits, 1'b0, 8'h00, 6'b0, 0, o);
      model_phase(tbl[i].p, tbl[i].data, tbl[i].waits, 1'b0, 8'h00, 6'b0, e);
      cmp_obs($sformatf("vec%0d", i), o, tbl[i].exp);
    end

    // Randomized phases against the model
    do_reset();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 7) p = 6'(1 << $urandom_range(0, 5));
      else                          p = 6'($urandom_range(0, 63));
      data  = 8'($urandom);
      waits = ($urandom_range(0, 7) == 0) ? -1 :
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 16)) :
                                            int'($urandom_range(0, 4));
      ld    = ($urandom_range(0, 3) == 0);
      ldv   = 8'($urandom);
      run_phase(p, data, waits, ld, ldv, 6'b0, 0, o);
      model_phase(p, data, waits, ld, ldv, 6'b0, e);
      cmp_obs($sformatf("rnd%0d", n), o, e);
    end

    // Start pulse while busy: ignored, flags overlap, only one done
    do_reset();
    run_phase(6'b001000, 8'h5A, 3, 1'b0, 8'h00, 6'b000100, 2, o);
    model_phase(6'b001000, 8'h5A, 3, 1'b0, 8'h00, 6'b000100, e);
    cmp_obs("busy_pulse", o, e);

    // PC load together with an opcode fetch: the read uses the loaded value
    do_reset();
    run_phase(6'b100000, 8'h07, 0, 1'b1, 8'h80, 6'b0, 0, o);
    model_phase(6'b100000, 8'h07, 0, 1'b1, 8'h80, 6'b0, e);
    cmp_obs("pc_load", o, e);
    chk("pc_load.addr_const", o.addr, 8'h80);
    chk("pc_load.pc_const", o.pc, 8'h81);

    // Reset in the middle of a request abandons it
    @(posedge clk); #1;
    set_pulses(6'b100000);
    pc_load = 1'b1;
    pc_load_val = 8'h40;
    @(posedge clk); #1;
    set_pulses(6'b0);
    pc_load = 1'b0;
    @(negedge clk);
    chk("midreq.mem_req_before", mem_req, 1'b1);
    chk("midreq.addr_before", mem_addr, 8'h40);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreq.mem_req_after", mem_req, 1'b0);
    chk("midreq.pc_after", pc, 8'h00);
    chk("midreq.opcode_after", opcode, 8'h00);
    nd = 0; nr = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      mem_ack = (c < 3);
      mem_rdata = 8'hC3;
      @(negedge clk);
      if (done) nd++;
      if (mem_req) nr++;
    end
    mem_ack = 1'b0;
    chk("midreq.no_done", nd, 0);
    chk("midreq.no_req", nr, 0);
    chk("midreq.pc_stays", pc, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
